// File: rtl/sp_mc_ctrl.sv
// sp_mc_ctrl: multi-cycle FETCH/DECODE/EXEC/MEM/WB/DONE sequencer for the shared-ALU datapath
//
// Ports:
//   clk, rst                 clock (rising edge), synchronous active-high reset
//   in_valid_i               host permits the next instruction to start
//   opcode_i, func_i         IR[31:26] / IR[5:0], valid from DECODE onward
//   mem_ready_i              data memory completes the current access
//   ir_we_o, pc_we_o         latch IR / advance PC
//   rf_we_o, reg_dst_o       register file write, 1 = rd else rt
//   alu_src_o, alu_op_o      operand B select, ALU function
//   imm_zext_o, lui_sel_o    immediate zero-extend, writeback {imm,16'h0}
//   mem_req_o, mem_we_o      memory request, store
//   mem_to_reg_o             writeback selects memory read data
//   out_valid_o, illegal_o   retire pulse, undecodable qualifier
//   instr_cnt_o              retired-instruction count (wraps)
//   mem_err_o                memory timeout pulse in DONE
//
// Build option: define MEM_TIMEOUT_EN to abort MEM after MEM_TIMEOUT stalled cycles.
module sp_mc_ctrl #(
    parameter int CNT_W       = 32,
    parameter int MEM_TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid_i,
    input  logic [5:0]       opcode_i,
    input  logic [5:0]       func_i,
    input  logic             mem_ready_i,
    output logic             ir_we_o,
    output logic             pc_we_o,
    output logic             rf_we_o,
    output logic             reg_dst_o,
    output logic             alu_src_o,
    output logic [2:0]       alu_op_o,
    output logic             imm_zext_o,
    output logic             lui_sel_o,
    output logic             mem_req_o,
    output logic             mem_we_o,
    output logic             mem_to_reg_o,
    output logic             out_valid_o,
    output logic             illegal_o,
    output logic [CNT_W-1:0] instr_cnt_o,
    output logic             mem_err_o
);
    typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXEC, MEM, WB, DONE} state_t;

    state_t     state_q, state_d;
    logic [5:0] op_q, fn_q;
    logic [5:0] op, fn;
    logic       r_type, legal, is_lw, is_sw, is_lui, zext, timeout;
    logic [2:0] alu_op;

    // The IR only holds the new instruction from DECODE on, so decode the live
    // inputs there and the captured copy afterwards.
    assign op      = (state_q == DECODE) ? opcode_i : op_q;
    assign fn      = (state_q == DECODE) ? func_i : fn_q;
    assign r_type  = op == 6'd0;
    assign is_lw   = op == 6'd5;
    assign is_sw   = op == 6'd6;
    assign is_lui  = op == 6'd9;
    assign zext    = op == 6'd1 || op == 6'd2;
    assign legal   = r_type ? fn <= 6'd6 : (op >= 6'd1 && op <= 6'd6) || is_lui;
    assign alu_op  = r_type ? fn[2:0] : op == 6'd1 ? 3'd0 : op == 6'd2 ? 3'd1 : op == 6'd4 ? 3'd3 : 3'd2;

`ifdef MEM_TIMEOUT_EN
    localparam int WT_W = $clog2(MEM_TIMEOUT + 1);
    logic [WT_W-1:0] wait_q;
    logic            mem_err_q;

    // Fires on the last permitted stalled MEM cycle, so MEM lasts MEM_TIMEOUT cycles.
    assign timeout   = !mem_ready_i && wait_q == WT_W'(MEM_TIMEOUT - 1);
    assign mem_err_o = mem_err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            wait_q    <= '0;
            mem_err_q <= 1'b0;
        end else begin
            wait_q    <= (state_q == MEM && state_d == MEM) ? wait_q + WT_W'(!mem_ready_i) : '0;
            mem_err_q <= state_q == MEM && timeout;
        end
    end
`else
    // No wait counter: MEM waits forever; the compare is constant false.
    assign timeout   = MEM_TIMEOUT < 0;
    assign mem_err_o = 1'b0;
`endif

    always_comb begin
        state_d = IDLE;
        case (state_q)
            IDLE:    state_d = in_valid_i ? FETCH : IDLE;
            FETCH:   state_d = DECODE;
            DECODE:  state_d = legal ? EXEC : DONE;
            EXEC:    state_d = (is_lw || is_sw) ? MEM : WB;
            MEM:     state_d = mem_ready_i ? (is_lw ? WB : DONE) : timeout ? DONE : MEM;
            WB:      state_d = DONE;
            DONE:    state_d = in_valid_i ? FETCH : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs are registered from the next state so each is a clean Moore decode.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            op_q         <= '0;
            fn_q         <= '0;
            ir_we_o      <= 1'b0;
            pc_we_o      <= 1'b0;
            rf_we_o      <= 1'b0;
            reg_dst_o    <= 1'b0;
            alu_src_o    <= 1'b0;
            alu_op_o     <= '0;
            imm_zext_o   <= 1'b0;
            lui_sel_o    <= 1'b0;
            mem_req_o    <= 1'b0;
            mem_we_o     <= 1'b0;
            mem_to_reg_o <= 1'b0;
            out_valid_o  <= 1'b0;
            illegal_o    <= 1'b0;
            instr_cnt_o  <= '0;
        end else begin
            state_q      <= state_d;
            op_q         <= op;
            fn_q         <= fn;
            ir_we_o      <= state_d == FETCH;
            pc_we_o      <= state_d == DONE;
            rf_we_o      <= state_d == WB;
            reg_dst_o    <= (state_d == EXEC || state_d == WB) && r_type;
            alu_src_o    <= state_d == EXEC && !r_type;
            alu_op_o     <= state_d == EXEC ? alu_op : 3'd0;
            imm_zext_o   <= state_d == EXEC && zext;
            lui_sel_o    <= state_d == WB && is_lui;
            mem_req_o    <= state_d == MEM;
            mem_we_o     <= state_d == MEM && is_sw;
            mem_to_reg_o <= state_d == WB && is_lw;
            out_valid_o  <= state_d == DONE;
            illegal_o    <= state_d == DONE && !legal;
            instr_cnt_o  <= instr_cnt_o + CNT_W'(state_d == DONE);
        end
    end
endmodule

// File: tb/tb_sp_mc_ctrl.sv
// tb_sp_mc_ctrl: directed cycle-by-cycle check of the sp_mc_ctrl sequencer
module tb_sp_mc_ctrl;
    logic        clk = 1'b0;
    logic        rst, in_valid, mem_ready;
    logic [5:0]  opcode, func;
    logic        ir_we, pc_we, rf_we, reg_dst, alu_src, imm_zext, lui_sel;
    logic        mem_req, mem_we, mem_to_reg, out_valid, illegal, mem_err;
    logic [2:0]  alu_op;
    logic [31:0] instr_cnt;
    int          n_cmp = 0, n_err = 0;

    localparam logic [15:0] IR = 16'h8000, PC = 16'h4000, RF = 16'h2000, RD = 16'h1000;
    localparam logic [15:0] AS = 16'h0800, ZX = 16'h0080, LU = 16'h0040, MR = 16'h0020;
    localparam logic [15:0] MW = 16'h0010, M2R = 16'h0008, OV = 16'h0004, IL = 16'h0002;
    localparam logic [15:0] ME = 16'h0001, ADD = 16'h0200, SUB = 16'h0300;

    wire [15:0] outs = {ir_we, pc_we, rf_we, reg_dst, alu_src, alu_op, imm_zext, lui_sel,
                        mem_req, mem_we, mem_to_reg, out_valid, illegal, mem_err};

    sp_mc_ctrl #(.CNT_W(32), .MEM_TIMEOUT(16)) dut (
        .clk(clk), .rst(rst), .in_valid_i(in_valid), .opcode_i(opcode), .func_i(func),
        .mem_ready_i(mem_ready), .ir_we_o(ir_we), .pc_we_o(pc_we), .rf_we_o(rf_we),
        .reg_dst_o(reg_dst), .alu_src_o(alu_src), .alu_op_o(alu_op), .imm_zext_o(imm_zext),
        .lui_sel_o(lui_sel), .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_to_reg_o(mem_to_reg),
        .out_valid_o(out_valid), .illegal_o(illegal), .instr_cnt_o(instr_cnt), .mem_err_o(mem_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic cyc(input string tag, input logic [15:0] exp);
        @(posedge clk);
        #1;
        chk(tag, {16'h0, outs}, {16'h0, exp});
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b1; opcode = 6'd0; func = 6'd2; mem_ready = 1'b0;
        cyc("rst0", 0);
        cyc("rst1", 0);
        chk("rst_cnt", instr_cnt, 0);
        rst = 1'b0;
        cyc("add_c0", IR);
        cyc("add_c1", 0);
        cyc("add_c2", RD | ADD);
        cyc("add_c3", RF | RD);
        cyc("add_c4", PC | OV);
        chk("add_cnt", instr_cnt, 1);
        opcode = 6'd5;
        cyc("lw_c0", IR);
        cyc("lw_c1", 0);
        in_valid = 1'b0;
        cyc("lw_c2", AS | ADD);
        cyc("lw_c3", MR);
        cyc("lw_c4", MR);
        cyc("lw_c5", MR);
        cyc("lw_c6", MR);
        mem_ready = 1'b1;
        cyc("lw_c7", RF | M2R);
        cyc("lw_c8", PC | OV);
        cyc("idle0", 0);
        cyc("idle1", 0);
        chk("lw_cnt", instr_cnt, 2);
        opcode = 6'd6; in_valid = 1'b1;
        cyc("sw_c0", IR);
        cyc("sw_c1", 0);
        cyc("sw_c2", AS | ADD);
        cyc("sw_c3", MR | MW);
        cyc("sw_c4", PC | OV);
        opcode = 6'd1;
        cyc("andi_c0", IR);
        cyc("andi_c1", 0);
        cyc("andi_c2", AS | ZX);
        cyc("andi_c3", RF);
        cyc("andi_c4", PC | OV);
        opcode = 6'd3;
        cyc("addi_c0", IR);
        cyc("addi_c1", 0);
        cyc("addi_c2", AS | ADD);
        cyc("addi_c3", RF);
        cyc("addi_c4", PC | OV);
        opcode = 6'd4;
        cyc("subi_c0", IR);
        cyc("subi_c1", 0);
        cyc("subi_c2", AS | SUB);
        cyc("subi_c3", RF);
        cyc("subi_c4", PC | OV);
        opcode = 6'd9;
        cyc("lui_c0", IR);
        cyc("lui_c1", 0);
        @(posedge clk);
        #1;
        cyc("lui_c3", RF | LU);
        cyc("lui_c4", PC | OV);
        opcode = 6'd7;
        cyc("op7_c0", IR);
        cyc("op7_c1", 0);
        cyc("op7_c2", PC | OV | IL);
        opcode = 6'd0; func = 6'd7;
        cyc("fn7_c0", IR);
        cyc("fn7_c1", 0);
        cyc("fn7_c2", PC | OV | IL);
        chk("cnt9", instr_cnt, 9);
        opcode = 6'd6; mem_ready = 1'b0;
        cyc("swr_c0", IR);
        cyc("swr_c1", 0);
        cyc("swr_c2", AS | ADD);
        cyc("swr_c3", MR | MW);
        rst = 1'b1;
        cyc("swr_rst", 0);
        chk("swr_cnt", instr_cnt, 0);
        in_valid = 1'b0;
        cyc("swr_rst2", 0);
        rst = 1'b0;
        cyc("post_idle0", 0);
        cyc("post_idle1", 0);
`ifdef MEM_TIMEOUT_EN
        in_valid = 1'b1; opcode = 6'd5;
        cyc("to_c0", IR);
        in_valid = 1'b0;
        cyc("to_c1", 0);
        cyc("to_c2", AS | ADD);
        for (int k = 3; k <= 18; k++) cyc("to_mem", MR);
        cyc("to_c19", PC | OV | ME);
        cyc("to_idle", 0);
        chk("to_cnt", instr_cnt, 1);
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
